line_cache_3x3: RTL and testbench
=================================

Name: line_cache_3x3

Overview:
- Responder side of the display pipeline's line-cache request interface.
- Stores captured GBA pixels (240x160, 24-bit RGB) in a 4-line ring buffer.
- Serves a 3x3 pixel neighbourhood around the pixel index requested by the HDMI image generator.
- Moves its read line forward on `nextLine` requests, and reports on `sameLine` when the next line is not yet available.

Parameters:
- LINE_W, 240, pixels per GBA line.
- LINE_H, 160, lines per GBA frame.
- RING_LINES, 4, line slots in the ring buffer; must be a power of two and at least 4.

Ports:
- pxlClk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- wrEn  in  1  pixel write strobe, already synchronous to pxlClk.
- wrData  in  24  pixel written on wrEn, packed {r,g,b}.
- wrLineEnd  in  1  pulse: current captured line is complete.
- wrFrameStart  in  1  pulse: a new frame begins; sampled before its first wrEn.
- curPxl  in  8  requested pixel index, 0..LINE_W-1.
- nextLine  in  1  pulse: reader requests advance to the next line.
- cacheUpdate  in  1  pulse at end of visible line: commits the pending read line.
- prevLineOut  out  72  line above the current line, packed {prevPxl,curPxl,nextPxl}, each {r,g,b}.
- curLineOut  out  72  current line, same packing.
- nextLineOut  out  72  line below the current line, same packing.
- sameLine  out  1  1 = advancing now would starve the reader; the reader repeats the line.
- newFrameOut  out  1  one-cycle pulse, one cycle after wrFrameStart is accepted.

Behaviour:
- Reset: all outputs are 0, except `sameLine`, which is 1. Internal state at reset: wrX=0, wrCnt=0, rdIdx=0, actIdx=0. Memory contents are don't-care.
- Write side:
  - On wrEn, write wrData to slot (wrCnt mod RING_LINES), position wrX, then increment wrX.
  - If wrX==LINE_W-1, wrX holds and further wrEn on the line overwrite position 239 (no wrap).
  - On wrLineEnd: wrX<=0 and wrCnt<=wrCnt+1, saturating at LINE_H.
  - If wrEn and wrLineEnd occur in the same cycle, the pixel is written to the old line first.
- Frame start: wrFrameStart takes priority over all other inputs in that cycle. It sets wrX, wrCnt, rdIdx and actIdx to 0, and the next cycle pulses newFrameOut=1.
- sameLine (registered) is 1 when:
  - rdIdx==LINE_H-1, or
  - wrCnt < min(rdIdx+3, LINE_H).
  It is 0 otherwise.
- nextLine: if nextLine==1 and sameLine==0 in that cycle, rdIdx<=rdIdx+1. It is ignored when sameLine==1.
- cacheUpdate: actIdx<=rdIdx. If nextLine is accepted in the same cycle, actIdx takes the incremented value, visible one cycle later.
- Row selection uses actIdx:
  - cur row = actIdx.
  - prev row = actIdx-1; clamps to actIdx when actIdx==0.
  - next row = actIdx+1; clamps to actIdx when actIdx==LINE_H-1.
  - Slot for any row = row mod RING_LINES.
- Column selection (horizontal clamp):
  - prev column = curPxl-1; clamps to curPxl when curPxl==0.
  - next column = min(curPxl+1, LINE_W-1).
  - curPxl values >= LINE_W are treated as LINE_W-1.
- Latency: outputs at cycle N+2 reflect curPxl and actIdx sampled at cycle N.
  - The structure is free: replicated RAMs or a shift window.
  - The observed values must match this definition exactly, including at clamped edges.
- A write to a slot being read in the same cycle returns the old data.
- Reset asserted mid-line or mid-frame restores the reset state on the next edge. No outputs glitch beyond the pipelined data that is already registered.

Optional Feature:
- Macro: LINE_CACHE_OVERRUN_CNT_EN.
- When defined, two extra outputs are added:
  - overrun (out, 1): sticky flag.
  - overrunCnt (out, 8): saturating counter.
- An overrun event is a wrLineEnd that makes wrCnt >= rdIdx+RING_LINES-1 (writer enters the slot of the prev row).
  - On each event: overrunCnt increments, saturating at 255, and overrun<=1.
  - Both clear only on rst.
  - wrFrameStart does not clear them.
- When undefined, the ports and logic are absent. Write behaviour is identical in both builds: overrun is never blocked.

Test Plan:
- Reset, then idle -> all outputs are 0 except sameLine=1; newFrameOut stays 0.
- wrFrameStart, then write 3 lines with pixel = {line, x, 8'h00} -> sameLine=0 from 1 cycle after the 3rd wrLineEnd; with curPxl=5, curLineOut={(0,4,0),(0,5,0),(0,6,0)}; prevLineOut equals curLineOut (top clamp); nextLineOut row=1; valid 2 cycles after curPxl is applied.
- curPxl=0 and curPxl=239 -> prev pixel = cur pixel at x=0; next pixel = cur pixel at x=239; curPxl=250 gives the same outputs as 239.
- Only 2 lines written, then pulse nextLine+cacheUpdate -> sameLine=1, rdIdx is unchanged, outputs still show row 0. After the 3rd line is written, repeating the pulse moves the rows to 1 and 2.
- Full frame of 160 lines, reader advanced to actIdx=159 -> nextLineOut==curLineOut; sameLine=1; a further nextLine is ignored.
- With LINE_CACHE_OVERRUN_CNT_EN defined: hold rdIdx=0 and write 3 lines -> overrun=1, overrunCnt=1 (event at wrCnt=3). Write 300 more lines -> overrunCnt=255. wrFrameStart -> both are unchanged; rst -> both are 0.

Source files
------------

// File: rtl/line_cache_3x3_if.sv
// Write, request and response bundle of the 3x3 line cache.
// Overrun status signals exist only when LINE_CACHE_OVERRUN_CNT_EN is defined.
interface line_cache_3x3_if;
  logic        wrEn;
  logic [23:0] wrData;
  logic        wrLineEnd;
  logic        wrFrameStart;
  logic [7:0]  curPxl;
  logic        nextLine;
  logic        cacheUpdate;
  logic [71:0] prevLineOut;
  logic [71:0] curLineOut;
  logic [71:0] nextLineOut;
  logic        sameLine;
  logic        newFrameOut;
`ifdef LINE_CACHE_OVERRUN_CNT_EN
  logic        overrun;
  logic [7:0]  overrunCnt;
`endif

  modport master (
    output wrEn, wrData, wrLineEnd, wrFrameStart, curPxl, nextLine, cacheUpdate,
`ifdef LINE_CACHE_OVERRUN_CNT_EN
    input  overrun, overrunCnt,
`endif
    input  prevLineOut, curLineOut, nextLineOut, sameLine, newFrameOut
  );

  modport slave (
    input  wrEn, wrData, wrLineEnd, wrFrameStart, curPxl, nextLine, cacheUpdate,
`ifdef LINE_CACHE_OVERRUN_CNT_EN
    output overrun, overrunCnt,
`endif
    output prevLineOut, curLineOut, nextLineOut, sameLine, newFrameOut
  );
endinterface

// File: rtl/line_cache_3x3.sv
// Ring-buffered GBA line cache serving a 3x3 pixel neighbourhood to the HDMI generator.
// Optional overrun flag/counter: define LINE_CACHE_OVERRUN_CNT_EN.
module line_cache_3x3 #(
  parameter int LINE_W     = 240,
  parameter int LINE_H     = 160,
  parameter int RING_LINES = 4
) (
  input  logic             pxlClk,
  input  logic             rst,
  line_cache_3x3_if.slave  bus
);

  localparam int SLOT_W = $clog2(RING_LINES);

  logic [23:0] mem [RING_LINES][LINE_W];

  logic [7:0] wrXQ, wrXD;
  logic [7:0] wrCntQ, wrCntD;
  logic [7:0] rdIdxQ, rdIdxD;
  logic [7:0] actIdxQ, actIdxD;
  logic       sameLineQ, sameLineD;
  logic       newFrameQ, newFrameD;
  logic [8:0] rdLimit;

  logic [7:0] colC, colP, colN;
  logic [7:0] rowP, rowN;
  logic [SLOT_W-1:0] slotPQ, slotCQ, slotNQ;
  logic [7:0] colPQ, colCQ, colNQ;
  logic [71:0] prevLineQ, curLineQ, nextLineQ;

`ifdef LINE_CACHE_OVERRUN_CNT_EN
  logic       overrunEvt;
  logic       overrunQ, overrunD;
  logic [7:0] overrunCntQ, overrunCntD;
`endif

  always_comb begin
    wrXD      = wrXQ;
    wrCntD    = wrCntQ;
    rdIdxD    = rdIdxQ;
    actIdxD   = actIdxQ;
    newFrameD = 1'b0;
    if (bus.wrFrameStart) begin
      wrXD      = '0;
      wrCntD    = '0;
      rdIdxD    = '0;
      actIdxD   = '0;
      newFrameD = 1'b1;
    end else begin
      if (bus.wrEn && (wrXQ != 8'(LINE_W - 1))) begin
        wrXD = wrXQ + 8'd1;
      end
      if (bus.wrLineEnd) begin
        wrXD = '0;
        if (wrCntQ != 8'(LINE_H)) begin
          wrCntD = wrCntQ + 8'd1;
        end
      end
      if (bus.nextLine && !sameLineQ) begin
        rdIdxD = rdIdxQ + 8'd1;
      end
      if (bus.cacheUpdate) begin
        actIdxD = rdIdxD;
      end
    end
  end

  // sameLine is judged on the post-edge counters so a just-accepted advance is seen immediately.
  always_comb begin
    rdLimit = 9'(rdIdxD) + 9'd3;
    if (rdLimit > 9'(LINE_H)) begin
      rdLimit = 9'(LINE_H);
    end
    sameLineD = (rdIdxD == 8'(LINE_H - 1)) || (9'(wrCntD) < rdLimit);
  end

`ifdef LINE_CACHE_OVERRUN_CNT_EN
  always_comb begin
    overrunEvt  = bus.wrLineEnd && !bus.wrFrameStart &&
                  (9'(wrCntD) >= (9'(rdIdxQ) + 9'(RING_LINES - 1)));
    overrunD    = overrunQ;
    overrunCntD = overrunCntQ;
    if (overrunEvt) begin
      overrunD = 1'b1;
      if (overrunCntQ != 8'hFF) begin
        overrunCntD = overrunCntQ + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wrXQ      <= '0;
      wrCntQ    <= '0;
      rdIdxQ    <= '0;
      actIdxQ   <= '0;
      sameLineQ <= 1'b1;
      newFrameQ <= 1'b0;
    end else begin
      wrXQ      <= wrXD;
      wrCntQ    <= wrCntD;
      rdIdxQ    <= rdIdxD;
      actIdxQ   <= actIdxD;
      sameLineQ <= sameLineD;
      newFrameQ <= newFrameD;
    end
  end

`ifdef LINE_CACHE_OVERRUN_CNT_EN
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      overrunQ    <= 1'b0;
      overrunCntQ <= '0;
    end else begin
      overrunQ    <= overrunD;
      overrunCntQ <= overrunCntD;
    end
  end
`endif

  // Pixel writes land in the slot of the line being captured; frame start suppresses them.
  always_ff @(posedge pxlClk) begin
    if (!rst && !bus.wrFrameStart && bus.wrEn) begin
      mem[wrCntQ[SLOT_W-1:0]][wrXQ] <= bus.wrData;
    end
  end

  always_comb begin
    colC = (bus.curPxl >= 8'(LINE_W)) ? 8'(LINE_W - 1) : bus.curPxl;
    colP = (colC == 8'd0) ? colC : colC - 8'd1;
    colN = (colC == 8'(LINE_W - 1)) ? colC : colC + 8'd1;
    rowP = (actIdxQ == 8'd0) ? actIdxQ : actIdxQ - 8'd1;
    rowN = (actIdxQ == 8'(LINE_H - 1)) ? actIdxQ : actIdxQ + 8'd1;
  end

  // Stage 1 latches clamped addresses, stage 2 reads the ring (old data on a colliding write).
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      slotPQ    <= '0;
      slotCQ    <= '0;
      slotNQ    <= '0;
      colPQ     <= '0;
      colCQ     <= '0;
      colNQ     <= '0;
      prevLineQ <= '0;
      curLineQ  <= '0;
      nextLineQ <= '0;
    end else begin
      slotPQ    <= rowP[SLOT_W-1:0];
      slotCQ    <= actIdxQ[SLOT_W-1:0];
      slotNQ    <= rowN[SLOT_W-1:0];
      colPQ     <= colP;
      colCQ     <= colC;
      colNQ     <= colN;
      prevLineQ <= {mem[slotPQ][colPQ], mem[slotPQ][colCQ], mem[slotPQ][colNQ]};
      curLineQ  <= {mem[slotCQ][colPQ], mem[slotCQ][colCQ], mem[slotCQ][colNQ]};
      nextLineQ <= {mem[slotNQ][colPQ], mem[slotNQ][colCQ], mem[slotNQ][colNQ]};
    end
  end

  assign bus.prevLineOut = prevLineQ;
  assign bus.curLineOut  = curLineQ;
  assign bus.nextLineOut = nextLineQ;
  assign bus.sameLine    = sameLineQ;
  assign bus.newFrameOut = newFrameQ;
`ifdef LINE_CACHE_OVERRUN_CNT_EN
  assign bus.overrun     = overrunQ;
  assign bus.overrunCnt  = overrunCntQ;
`endif

endmodule

// File: tb/tb_line_cache_3x3.sv
// Scoreboard bench for line_cache_3x3: directed writes/requests, queued expectations.
// Overrun checks compile in when LINE_CACHE_OVERRUN_CNT_EN is defined.
`timescale 1ns/1ps
module tb_line_cache_3x3;
  logic pxlClk = 1'b0;
  logic rst = 1'b1;

  line_cache_3x3_if bus();

  line_cache_3x3 dut (
    .pxlClk (pxlClk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 pxlClk = ~pxlClk;

  typedef struct {
    string       name;
    logic [71:0] prevE;
    logic [71:0] curE;
    logic [71:0] nextE;
  } pixExp_t;

  typedef struct {
    string      name;
    logic       sameE;
    logic       nfE;
    logic       chkLines;
    logic       chkOv;
    logic       ovE;
    logic [7:0] ocE;
  } statExp_t;

  pixExp_t  pixQ[$];
  statExp_t statQ[$];
  pixExp_t  pe;
  statExp_t se;
  int checks = 0;
  int failures = 0;
  logic probeReq = 1'b0;
  logic probe0 = 1'b0;
  logic probe1 = 1'b0;
  logic doneReq = 1'b0;

  function automatic logic [23:0] px(input int line, input int x);
    return {8'(line), 8'(x), 8'h00};
  endfunction

  function automatic logic [71:0] trip(input int line, input int xp, input int xc, input int xn);
    return {px(line, xp), px(line, xc), px(line, xn)};
  endfunction

  // Response data is two cycles behind the request, so the probe flag is delayed to match.
  always @(posedge pxlClk) begin
    probe1 <= probe0;
    probe0 <= probeReq;
  end

  task automatic compare(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge pxlClk) begin
    if (probe1) begin
      if (pixQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL pixQueue: response with no expectation, got 1 expected 0");
      end else begin
        pe = pixQ.pop_front();
        compare({pe.name, " prev"}, bus.prevLineOut, pe.prevE);
        compare({pe.name, " cur"},  bus.curLineOut,  pe.curE);
        compare({pe.name, " next"}, bus.nextLineOut, pe.nextE);
      end
    end
    while (statQ.size() > 0) begin
      se = statQ.pop_front();
      compare({se.name, " sameLine"}, 72'(bus.sameLine), 72'(se.sameE));
      compare({se.name, " newFrame"}, 72'(bus.newFrameOut), 72'(se.nfE));
      if (se.chkLines) begin
        compare({se.name, " prevLine"}, bus.prevLineOut, 72'd0);
        compare({se.name, " curLine"},  bus.curLineOut,  72'd0);
        compare({se.name, " nextLine"}, bus.nextLineOut, 72'd0);
      end
`ifdef LINE_CACHE_OVERRUN_CNT_EN
      if (se.chkOv) begin
        compare({se.name, " overrun"},    72'(bus.overrun),    72'(se.ovE));
        compare({se.name, " overrunCnt"}, 72'(bus.overrunCnt), 72'(se.ocE));
      end
`endif
    end
    if (doneReq) begin
      compare("pixQueue drained", 72'(pixQ.size()), 72'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic applyStimulus(input logic we, input logic [23:0] d, input logic le,
                               input logic fs, input logic nl, input logic cu, input logic r);
    @(negedge pxlClk);
    rst              = r;
    bus.wrEn         = we;
    bus.wrData       = d;
    bus.wrLineEnd    = le;
    bus.wrFrameStart = fs;
    bus.nextLine     = nl;
    bus.cacheUpdate  = cu;
    probeReq         = 1'b0;
    @(posedge pxlClk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lineEnd();
    applyStimulus(1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic advance();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic frameStart();
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: plain line, 1: last pixel shares the line-end cycle, 2: extra write after x=239
  task automatic writeLine(input int line, input int mode);
    for (int x = 0; x < 239; x++) begin
      applyStimulus(1'b1, px(line, x), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (mode == 1) begin
      applyStimulus(1'b1, px(line, 239), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      applyStimulus(1'b1, px(line, 239), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (mode == 2) begin
        applyStimulus(1'b1, px(line, 8'hAB), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      lineEnd();
    end
  endtask

  task automatic requestPixel(input logic [7:0] p, input string name,
                              input logic [71:0] pE, input logic [71:0] cE, input logic [71:0] nE);
    pixExp_t e;
    @(negedge pxlClk);
    rst              = 1'b0;
    bus.wrEn         = 1'b0;
    bus.wrLineEnd    = 1'b0;
    bus.wrFrameStart = 1'b0;
    bus.nextLine     = 1'b0;
    bus.cacheUpdate  = 1'b0;
    bus.curPxl       = p;
    probeReq         = 1'b1;
    e.name  = name;
    e.prevE = pE;
    e.curE  = cE;
    e.nextE = nE;
    pixQ.push_back(e);
    @(posedge pxlClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic sameE, input logic nfE,
                             input logic chkLines, input logic chkOv, input logic ovE,
                             input logic [7:0] ocE);
    statExp_t e;
    e.name     = name;
    e.sameE    = sameE;
    e.nfE      = nfE;
    e.chkLines = chkLines;
    e.chkOv    = chkOv;
    e.ovE      = ovE;
    e.ocE      = ocE;
    statQ.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.wrEn = 1'b0;
    bus.wrData = 24'd0;
    bus.wrLineEnd = 1'b0;
    bus.wrFrameStart = 1'b0;
    bus.curPxl = 8'd0;
    bus.nextLine = 1'b0;
    bus.cacheUpdate = 1'b0;

    repeat (3) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    repeat (3) idle();
    checkOutput("idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    frameStart();
    checkOutput("newFrame pulse", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    idle();
    checkOutput("newFrame low", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    writeLine(0, 0);
    writeLine(1, 0);
    checkOutput("two lines", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    advance();
    checkOutput("advance blocked", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    requestPixel(8'd5, "blocked row0", trip(0, 4, 5, 6), trip(0, 4, 5, 6), trip(1, 4, 5, 6));

    writeLine(2, 1);
    checkOutput("three lines", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    requestPixel(8'd5,   "px5 row0",   trip(0, 4, 5, 6),       trip(0, 4, 5, 6),       trip(1, 4, 5, 6));
    requestPixel(8'd0,   "px0 row0",   trip(0, 0, 0, 1),       trip(0, 0, 0, 1),       trip(1, 0, 0, 1));
    requestPixel(8'd239, "px239 row0", trip(0, 238, 239, 239), trip(0, 238, 239, 239), trip(1, 238, 239, 239));
    requestPixel(8'd250, "px250 row0", trip(0, 238, 239, 239), trip(0, 238, 239, 239), trip(1, 238, 239, 239));

    advance();
    checkOutput("advance to row1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    requestPixel(8'd5,   "px5 row1",   trip(0, 4, 5, 6),       trip(1, 4, 5, 6),       trip(2, 4, 5, 6));
    requestPixel(8'd239, "px239 row1", trip(0, 238, 239, 239), trip(1, 238, 239, 239), trip(2, 238, 239, 239));

    repeat (154) lineEnd();
    writeLine(157, 0);
    writeLine(158, 0);
    writeLine(159, 2);
    checkOutput("frame full", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (158) advance();
    checkOutput("bottom reached", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    requestPixel(8'd5, "px5 row159", trip(158, 4, 5, 6), trip(159, 4, 5, 6), trip(159, 4, 5, 6));
    requestPixel(8'd239, "px239 row159", trip(158, 238, 239, 239),
                 {px(159, 238), px(159, 8'hAB), px(159, 8'hAB)},
                 {px(159, 238), px(159, 8'hAB), px(159, 8'hAB)});
    advance();
    checkOutput("nextLine ignored", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    requestPixel(8'd5, "px5 after ignore", trip(158, 4, 5, 6), trip(159, 4, 5, 6), trip(159, 4, 5, 6));
    repeat (3) idle();

    applyStimulus(1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid-frame reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idle();

    frameStart();
    checkOutput("ovr frame start", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    lineEnd();
    lineEnd();
    checkOutput("ovr two lines", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    lineEnd();
    checkOutput("ovr first event", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    repeat (300) lineEnd();
    checkOutput("ovr saturated", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255);
    frameStart();
    checkOutput("ovr kept on frame", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255);
    applyStimulus(1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr cleared by rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idle();
    idle();
    doneReq = 1'b1;
  end

endmodule
